// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
// Holds RV32 opcode constants, the controller state enum, the forwarding
// select encoding and helpers that decode which source registers an opcode reads.
package pipe_ctrl_pkg;

    localparam logic [6:0] R_TYPE = 7'b0110011;
    localparam logic [6:0] I_TYPE = 7'b0010011;
    localparam logic [6:0] U_TYPE = 7'b0110111;
    localparam logic [6:0] LW     = 7'b0000011;
    localparam logic [6:0] SW     = 7'b0100011;
    localparam logic [6:0] BR     = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] HALT   = 7'b0000000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_sel_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return op inside {R_TYPE, I_TYPE, LW, SW, BR, JALR};
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {R_TYPE, SW, BR};
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select for one source register.
// Ports:
//   ex_rs_i        source register of the instruction in EX
//   mem_rd_i/_regwrite_i  destination of the instruction in MEM
//   wb_rd_i/_regwrite_i   destination of the instruction in WB
//   fwd_sel_o      00 regfile, 10 EX/MEM, 01 MEM/WB
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_regwrite_i,
    output logic [1:0] fwd_sel_o
);

    // The younger producer (MEM) wins over the older one (WB); x0 never forwards.
    always_comb begin
        fwd_sel_o = FWD_REGFILE;
        if (mem_regwrite_i && (mem_rd_i != 5'd0) && (mem_rd_i == ex_rs_i)) begin
            fwd_sel_o = FWD_MEM;
        end else if (wb_regwrite_i && (wb_rd_i != 5'd0) && (wb_rd_i == ex_rs_i)) begin
            fwd_sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencing controller for a 5-stage RISC-V pipeline.
// Drives PC / pipeline-register enables and flushes, resolves load-use stalls,
// redirect flushes and memory-wait freezes, sequences the halt instruction through
// a drain-then-stop FSM, and runs a memory-wait watchdog.
// Ports:
//   clk_i, reset_i              clock, synchronous active-high reset
//   id_*_i                      instruction in ID (opcode, valid, rs1, rs2)
//   ex_*_i                      EX rd, load flag, regwrite, taken redirect
//   mem_rd_i/mem_regwrite_i     MEM destination
//   wb_rd_i/wb_regwrite_i       WB destination
//   mem_busy_i                  data memory not ready
//   pc_write_o, ifid_write_o    PC and IF/ID enables
//   ifid_flush_o, idex_flush_o  bubble insertion
//   pipe_en_o                   EX/MEM and MEM/WB enable
//   forward_a_o, forward_b_o    EX operand forwarding selects
//   halted_o, mem_err_o         core stopped, sticky watchdog error
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MEM_TIMEOUT  = 64
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [6:0] id_opcode_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_memread_i,
    input  logic       ex_regwrite_i,
    input  logic       ex_pc_sel_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_regwrite_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_regwrite_i,
    input  logic       mem_busy_i,
    output logic       pc_write_o,
    output logic       ifid_write_o,
    output logic       ifid_flush_o,
    output logic       idex_flush_o,
    output logic       pipe_en_o,
    output logic [1:0] forward_a_o,
    output logic [1:0] forward_b_o,
    output logic       halted_o,
    output logic       mem_err_o
);

    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic [TW-1:0]   wd_q, wd_d;
    logic            err_q, err_d;
    logic [4:0]      ex_rs1_q, ex_rs1_d;
    logic [4:0]      ex_rs2_q, ex_rs2_d;

    logic            load_use;
    logic            halt_det;

    // EX-stage regwrite is not needed: forwarding only sources from MEM and WB.
    logic            unused_ex_regwrite;
    assign unused_ex_regwrite = ex_regwrite_i;

    always_comb begin
        load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                   ((uses_rs1(id_opcode_i) && (ex_rd_i == id_rs1_i)) ||
                    (uses_rs2(id_opcode_i) && (ex_rd_i == id_rs2_i)));
        // A halt on a redirected (wrong) path or during a freeze is not taken yet.
        halt_det = id_valid_i && (id_opcode_i == HALT) && !ex_pc_sel_i && !mem_busy_i;
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= RUN;
            drain_q  <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            ex_rs1_q <= 5'd0;
            ex_rs2_q <= 5'd0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;

        // Watchdog saturates so the sticky error cannot wrap around.
        if (!mem_busy_i) begin
            wd_d = '0;
        end else if (wd_q == TW'(MEM_TIMEOUT)) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 1'b1;
        end
        err_d = err_q | (mem_busy_i && (wd_q == TW'(MEM_TIMEOUT - 1)));

        unique case (state_q)
            RUN: begin
                if (halt_det) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                // Only cycles where the back end actually advanced count as drained.
                if (!mem_busy_i) begin
                    if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                        state_d = HALTED;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // The error is registered first, so the stop lands one edge after it.
        if (err_q) begin
            state_d = HALTED;
        end
    end

    // Output logic
    always_comb begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        ifid_flush_o = 1'b0;
        idex_flush_o = 1'b0;
        pipe_en_o    = 1'b1;
        halted_o     = (state_q == HALTED);
        mem_err_o    = err_q;

        if (!reset_i) begin
            unique case (state_q)
                RUN: begin
                    if (mem_busy_i) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        pipe_en_o    = 1'b0;
                    end else if (ex_pc_sel_i) begin
                        ifid_flush_o = 1'b1;
                        idex_flush_o = 1'b1;
                    end else if (load_use || halt_det) begin
                        pc_write_o   = 1'b0;
                        ifid_write_o = 1'b0;
                        idex_flush_o = 1'b1;
                    end
                end
                DRAIN: begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    idex_flush_o = 1'b1;
                    pipe_en_o    = !mem_busy_i;
                end
                HALTED: begin
                    pc_write_o   = 1'b0;
                    ifid_write_o = 1'b0;
                    idex_flush_o = 1'b1;
                    pipe_en_o    = 1'b0;
                end
                default: begin
                    pc_write_o = 1'b1;
                end
            endcase
        end
    end

    // Shadow of the ID/EX source fields for forwarding; a bubble carries x0.
    always_comb begin
        ex_rs1_d = ex_rs1_q;
        ex_rs2_d = ex_rs2_q;
        if (idex_flush_o) begin
            ex_rs1_d = 5'd0;
            ex_rs2_d = 5'd0;
        end else if (pipe_en_o) begin
            ex_rs1_d = id_rs1_i;
            ex_rs2_d = id_rs2_i;
        end
    end

    forward_unit u_fwd_a (
        .ex_rs_i        (ex_rs1_q),
        .mem_rd_i       (mem_rd_i),
        .mem_regwrite_i (mem_regwrite_i),
        .wb_rd_i        (wb_rd_i),
        .wb_regwrite_i  (wb_regwrite_i),
        .fwd_sel_o      (forward_a_o)
    );

    forward_unit u_fwd_b (
        .ex_rs_i        (ex_rs2_q),
        .mem_rd_i       (mem_rd_i),
        .mem_regwrite_i (mem_regwrite_i),
        .wb_rd_i        (wb_rd_i),
        .wb_regwrite_i  (wb_regwrite_i),
        .fwd_sel_o      (forward_b_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table, hand-written
// drain/watchdog sequences, and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int unsigned DRAIN_CYCLES = 3;
    localparam int unsigned MEM_TIMEOUT  = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] id_opcode;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
    logic       ex_memread, ex_regwrite, ex_pc_sel, mem_regwrite, wb_regwrite, mem_busy;
    logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_en, halted, mem_err;
    logic [1:0] forward_a, forward_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .MEM_TIMEOUT  (MEM_TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .id_opcode_i    (id_opcode),
        .id_valid_i     (id_valid),
        .id_rs1_i       (id_rs1),
        .id_rs2_i       (id_rs2),
        .ex_rd_i        (ex_rd),
        .ex_memread_i   (ex_memread),
        .ex_regwrite_i  (ex_regwrite),
        .ex_pc_sel_i    (ex_pc_sel),
        .mem_rd_i       (mem_rd),
        .mem_regwrite_i (mem_regwrite),
        .wb_rd_i        (wb_rd),
        .wb_regwrite_i  (wb_regwrite),
        .mem_busy_i     (mem_busy),
        .pc_write_o     (pc_write),
        .ifid_write_o   (ifid_write),
        .ifid_flush_o   (ifid_flush),
        .idex_flush_o   (idex_flush),
        .pipe_en_o      (pipe_en),
        .forward_a_o    (forward_a),
        .forward_b_o    (forward_b),
        .halted_o       (halted),
        .mem_err_o      (mem_err)
    );

    // ctrl bit order: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en}
    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic       idv;
        logic [4:0] rs1, rs2, exrd;
        logic       exmr, expc;
        logic [4:0] memrd;
        logic       memrw;
        logic [4:0] wbrd;
        logic       wbrw, busy;
        logic [4:0] ctrl;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic rst, input logic [6:0] op, input logic idv,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] exrd, input logic exmr, input logic expc,
                                input logic [4:0] memrd, input logic memrw,
                                input logic [4:0] wbrd, input logic wbrw, input logic busy,
                                input logic [4:0] ctrl, input logic [1:0] fa,
                                input logic [1:0] fb);
        vec_t v;
        v.rst = rst; v.op = op; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.exrd = exrd;
        v.exmr = exmr; v.expc = expc; v.memrd = memrd; v.memrw = memrw; v.wbrd = wbrd;
        v.wbrw = wbrw; v.busy = busy; v.ctrl = ctrl; v.fa = fa; v.fb = fb;
        return v;
    endfunction

    function automatic logic [10:0] get_out();
        return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_en,
                forward_a, forward_b, halted, mem_err};
    endfunction

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic set_idle();
        reset = 1'b0; id_opcode = I_TYPE; id_valid = 1'b1; id_rs1 = 5'd0; id_rs2 = 5'd0;
        ex_rd = 5'd0; ex_memread = 1'b0; ex_regwrite = 1'b0; ex_pc_sel = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0;
        mem_busy = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; id_opcode = v.op; id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2;
        ex_rd = v.exrd; ex_memread = v.exmr; ex_regwrite = v.exmr; ex_pc_sel = v.expc;
        mem_rd = v.memrd; mem_regwrite = v.memrw; wb_rd = v.wbrd; wb_regwrite = v.wbrw;
        mem_busy = v.busy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_check(input string name, input logic [10:0] exp);
        @(negedge clk);
        check(name, get_out(), exp);
        tick();
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_mode;    // 0 running, 1 draining, 2 stopped
    int         m_left;    // drain bubbles still to retire
    int         m_streak;  // consecutive busy cycles
    logic       m_err;
    logic [4:0] m_rs1, m_rs2;

    function automatic logic reads1(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic reads2(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] r);
        if (mem_regwrite && mem_rd != 0 && mem_rd == r) return 2'b10;
        if (wb_regwrite && wb_rd != 0 && wb_rd == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_halt_now();
        return id_valid && id_opcode == 7'd0 && !ex_pc_sel && !mem_busy;
    endfunction

    function automatic logic [10:0] model_out();
        logic [4:0] ctrl;
        logic       lu;
        lu = ex_memread && ex_rd != 0 &&
             ((reads1(id_opcode) && ex_rd == id_rs1) || (reads2(id_opcode) && ex_rd == id_rs2));
        if (reset)                      ctrl = 5'b11001;
        else if (m_mode == 2)           ctrl = 5'b00010;
        else if (m_mode == 1)           ctrl = {4'b0001, !mem_busy};
        else if (mem_busy)              ctrl = 5'b00000;
        else if (ex_pc_sel)             ctrl = 5'b11111;
        else if (lu || m_halt_now())    ctrl = 5'b00011;
        else                            ctrl = 5'b11001;
        return {ctrl, fwd(m_rs1), fwd(m_rs2), m_mode == 2, m_err};
    endfunction

    task automatic model_clock(input logic [10:0] e);
        int   nxt;
        logic new_err;
        if (reset) begin
            m_mode = 0; m_left = 0; m_streak = 0; m_err = 1'b0; m_rs1 = 0; m_rs2 = 0;
        end else begin
            m_streak = mem_busy ? m_streak + 1 : 0;
            new_err  = m_err || (m_streak >= MEM_TIMEOUT);
            nxt = m_mode;
            if (m_mode == 0 && m_halt_now()) begin
                nxt = 1;
                m_left = DRAIN_CYCLES;
            end else if (m_mode == 1 && !mem_busy) begin
                m_left--;
                if (m_left == 0) nxt = 2;
            end
            if (m_err) nxt = 2;
            m_mode = nxt;
            m_err  = new_err;
            if (e[7]) begin
                m_rs1 = 0; m_rs2 = 0;
            end else if (e[6]) begin
                m_rs1 = id_rs1; m_rs2 = id_rs2;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [4:0]  pat;
        logic [10:0] e;
        logic [6:0]  ops[8];

        vecs[0]  = mk(1, R_TYPE, 1, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 2'b00, 2'b00);
        vecs[1]  = mk(0, R_TYPE, 1, 5, 7, 5, 1, 0, 0, 0, 0, 0, 0, 5'b00011, 2'b00, 2'b00);
        vecs[2]  = mk(0, R_TYPE, 1, 5, 7, 0, 0, 0, 5, 1, 0, 0, 0, 5'b11001, 2'b00, 2'b00);
        vecs[3]  = mk(0, I_TYPE, 1, 1, 2, 6, 0, 0, 0, 0, 5, 1, 0, 5'b11001, 2'b01, 2'b00);
        vecs[4]  = mk(0, U_TYPE, 1, 5, 0, 5, 1, 0, 1, 1, 1, 1, 0, 5'b11001, 2'b10, 2'b00);
        vecs[5]  = mk(0, R_TYPE, 1, 5, 3, 5, 1, 1, 5, 0, 5, 1, 0, 5'b11111, 2'b01, 2'b00);
        vecs[6]  = mk(0, SW,     1, 4, 0, 0, 1, 0, 0, 1, 0, 0, 0, 5'b11001, 2'b00, 2'b00);
        vecs[7]  = mk(0, BR,     1, 8, 9, 8, 1, 0, 4, 1, 0, 0, 1, 5'b00000, 2'b10, 2'b00);
        vecs[8]  = mk(0, BR,     1, 1, 4, 4, 1, 0, 0, 0, 4, 1, 0, 5'b00011, 2'b01, 2'b00);
        vecs[9]  = mk(0, I_TYPE, 1, 1, 4, 4, 1, 0, 0, 0, 0, 0, 0, 5'b11001, 2'b00, 2'b00);
        vecs[10] = mk(0, JAL,    1, 3, 3, 3, 1, 0, 4, 1, 1, 1, 0, 5'b11001, 2'b01, 2'b10);
        vecs[11] = mk(0, HALT,   1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0, 5'b11111, 2'b10, 2'b10);
        vecs[12] = mk(0, R_TYPE, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 2'b00, 2'b00);
        vecs[13] = mk(0, HALT,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 2'b00, 2'b00);
        vecs[14] = mk(0, HALT,   1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b00000, 2'b00, 2'b00);
        vecs[15] = mk(0, I_TYPE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 2'b00, 2'b00);

        set_idle();
        reset = 1'b1;
        tick();
        tick();

        // Directed vector table; rows depend on the EX shadow left by the row before.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            cycle_check($sformatf("vec%0d", i), {vecs[i].ctrl, vecs[i].fa, vecs[i].fb, 2'b00});
        end

        // Halt with two busy cycles inside DRAIN, a redirect ignored while draining.
        set_idle(); reset = 1'b1;
        cycle_check("seqa_reset", {5'b11001, 4'b0000, 1'b0, 1'b0});
        set_idle(); id_opcode = HALT;
        cycle_check("halt_decode", {5'b00011, 4'b0000, 1'b0, 1'b0});
        pat = 5'b00110;
        for (int k = 0; k < 5; k++) begin
            set_idle(); id_opcode = R_TYPE; mem_busy = pat[k]; ex_pc_sel = (k == 0);
            cycle_check($sformatf("drain%0d", k), {4'b0001, !pat[k], 4'b0000, 1'b0, 1'b0});
        end
        for (int k = 0; k < 3; k++) begin
            set_idle(); ex_pc_sel = k[0];
            cycle_check($sformatf("halted%0d", k), {5'b00010, 4'b0000, 1'b1, 1'b0});
        end

        // Watchdog: 64 busy cycles trip the error, the stop follows one edge later.
        set_idle(); reset = 1'b1;
        cycle_check("seqb_reset", {5'b11001, 4'b0000, 1'b1, 1'b0});
        set_idle(); mem_busy = 1'b1;
        for (int c = 1; c <= 63; c++) tick();
        cycle_check("wd_edge63", {5'b00000, 4'b0000, 1'b0, 1'b0});
        cycle_check("wd_err", {5'b00000, 4'b0000, 1'b0, 1'b1});
        set_idle();
        cycle_check("wd_halt", {5'b00010, 4'b0000, 1'b1, 1'b1});
        reset = 1'b1;
        cycle_check("wd_reset", {5'b11001, 4'b0000, 1'b1, 1'b1});
        set_idle();
        cycle_check("wd_clear", {5'b11001, 4'b0000, 1'b0, 1'b0});
        mem_busy = 1'b1;
        for (int c = 1; c <= 63; c++) tick();
        mem_busy = 1'b0;
        cycle_check("wd63_drop", {5'b11001, 4'b0000, 1'b0, 1'b0});
        mem_busy = 1'b1;
        cycle_check("wd63_rebusy", {5'b00000, 4'b0000, 1'b0, 1'b0});

        // Randomized traffic against the model.
        set_idle(); reset = 1'b1;
        tick();
        m_mode = 0; m_left = 0; m_streak = 0; m_err = 1'b0; m_rs1 = 0; m_rs2 = 0;
        ops = '{R_TYPE, I_TYPE, U_TYPE, LW, SW, BR, JAL, JALR};
        for (int n = 0; n < 3000; n++) begin
            int r;
            reset = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 39);
            id_opcode = (r == 0) ? HALT : ops[r % 8];
            id_valid = ($urandom_range(0, 7) != 0);
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            mem_rd = 5'($urandom_range(0, 3));
            wb_rd = 5'($urandom_range(0, 3));
            ex_memread = 1'($urandom_range(0, 1));
            ex_regwrite = 1'($urandom_range(0, 1));
            ex_pc_sel = ($urandom_range(0, 5) == 0);
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite = 1'($urandom_range(0, 1));
            mem_busy = ($urandom_range(0, 5) == 0);
            @(negedge clk);
            e = model_out();
            check("rand", get_out(), e);
            model_clock(e);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB); sits beside the main opcode decoder.
- Generates per-cycle enable/flush for the PC and pipeline registers, and the EX-stage forwarding selects.
- Resolves load-use stalls, taken-branch/jump flushes and data-memory wait freezes.
- Sequences the halt instruction (opcode 7'b0000000) through a drain-then-stop FSM, with a memory-wait watchdog.

Parameters:
DRAIN_CYCLES, 3, bubbles injected after halt is decoded so EX/MEM/WB retire older instructions
MEM_TIMEOUT, 64, consecutive mem_busy cycles before mem_err is raised
TW, $clog2(MEM_TIMEOUT+1), watchdog counter width (derived, not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
id_opcode  in  7  opcode of instruction in ID
id_valid  in  1  ID holds a real (non-bubble) instruction
id_rs1  in  5  ID source register 1
id_rs2  in  5  ID source register 2
ex_rd  in  5  EX destination register
ex_memread  in  1  EX instruction is a load
ex_regwrite  in  1  EX instruction writes rd
ex_pc_sel  in  1  EX branch taken or JAL/JALR redirect
mem_rd  in  5  MEM destination register
mem_regwrite  in  1  MEM instruction writes rd
wb_rd  in  5  WB destination register
wb_regwrite  in  1  WB instruction writes rd
mem_busy  in  1  data memory not ready this cycle
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID register enable
ifid_flush  out  1  IF/ID register loads bubble
idex_flush  out  1  ID/EX register loads bubble
pipe_en  out  1  EX/MEM and MEM/WB enable
forward_a  out  2  EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
forward_b  out  2  EX operand B select, same encoding
halted  out  1  core stopped
mem_err  out  1  sticky watchdog error

Behaviour:
- Reset (sync, high), values on the next edge:
  - state=RUN, watchdog=0, drain count=0, mem_err=0, halted=0.
  - Outputs during and after reset cycle: pc_write=1, ifid_write=1, flushes=0, pipe_en=1.
- rs usage decode:
  - rs1 used for R(0110011), I(0010011), LW, SW, BR, JALR.
  - rs2 used for R, SW, BR.
  - Register x0 never matches.
- Priority in RUN, highest first:
  1. mem_busy: pipe_en=0, pc_write=0, ifid_write=0, no flushes; full freeze.
  2. ex_pc_sel: ifid_flush=1, idex_flush=1, pc_write=1.
  3. Load-use: ex_memread, ex_rd!=0, and ex_rd matches a used rs. Result: pc_write=0, ifid_write=0, idex_flush=1. Exactly 1 bubble.
  4. Otherwise all enables 1, flushes 0.
- Halt detect: id_valid && id_opcode==0 && !ex_pc_sel && !mem_busy → next state DRAIN.
  - Same cycle: pc_write=0, ifid_write=0, idex_flush=1.
  - A branch taken in the same cycle discards the halt (wrong path).
- DRAIN:
  - pc_write=0, ifid_write=0, idex_flush=1, pipe_en=!mem_busy.
  - Counter increments only on cycles with !mem_busy.
  - After DRAIN_CYCLES counted cycles → HALTED.
  - ex_pc_sel is ignored in DRAIN (older instructions cannot redirect past a halt).
- HALTED:
  - halted=1, pc_write=0, ifid_write=0, pipe_en=0, idex_flush=1.
  - Terminal until reset.
- Watchdog:
  - Counts consecutive mem_busy cycles and clears when mem_busy=0.
  - On reaching MEM_TIMEOUT: mem_err=1 (sticky) and state→HALTED on the next edge.
- Forwarding (combinational, independent of state):
  - forward_a=10 if mem_regwrite, mem_rd!=0, and mem_rd==EX rs1. Requires EX rs1/rs2, registered internally from id_rs1/id_rs2 when the ID/EX register advances; cleared on idex_flush.
  - Otherwise 01 if the same conditions hold for wb.
  - Otherwise 00.
  - forward_b is the same for rs2.
  - EX/MEM has priority over MEM/WB.
- Reset mid-DRAIN or in HALTED returns to RUN with the counters cleared.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - Opcode constants: R_TYPE, I_TYPE, U_TYPE, LW, SW, BR, JAL, JALR, HALT.
  - State enum: RUN, DRAIN, HALTED.
  - Forward-select enum.
- Sub-module forward_unit: pure combinational forwarding logic, instantiated twice (A, B) or once with both outputs.

Test Plan:
- LW x5 in EX, ADD x6,x5,x7 in ID → one cycle with pc_write=0, ifid_write=0, idex_flush=1; next cycle forward_a=01 from WB, 10 impossible.
- LW x5 in EX, LUI x5 in ID (no rs use) → no stall; all enables 1.
- ex_pc_sel=1 with a load-use hazard present → ifid_flush=1, idex_flush=1, pc_write=1; no stall.
- Halt in ID, mem_busy held for 2 cycles inside DRAIN → halted rises exactly 3+2 cycles after the DRAIN entry edge; no PC writes after halt decode.
- ex_pc_sel=1 with halt in ID same cycle → stays RUN, halted never asserts.
- mem_busy held 64 cycles → mem_err=1 on edge 64, halted=1 the next cycle; reset clears both; mem_busy deasserted at cycle 63 → no error.
